// File: rtl/rib_arb_pkg.sv
// Shared types and helpers for the RIB round-robin master arbiter.
package rib_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned QUANTUM_DEF = 16;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping to 0.
module rib_rr_pick
  import rib_arb_pkg::*;
#(
  parameter int unsigned MST_NUM = 3,
  parameter int unsigned IDXW    = idx_w(MST_NUM)
) (
  input  logic [MST_NUM-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [IDXW-1:0]    idx,
  output logic               found
);

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= MST_NUM) s = s - MST_NUM;
    return IDXW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = int'(MST_NUM) - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        idx   = wrap_add(ptr, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin RIB master arbiter with quantum-bounded tenure and registered one-hot grant.
// Define RIB_ARB_LOCK_EN to let a locked owner keep the bus past its quantum.
module rib_rr_arbiter
  import rib_arb_pkg::*;
#(
  parameter int unsigned MST_NUM = 3,
  parameter int unsigned QUANTUM = QUANTUM_DEF,
  parameter int unsigned IDXW    = idx_w(MST_NUM)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [MST_NUM-1:0] req_mst,
  input  logic [MST_NUM-1:0] lock_mst,
  output logic [MST_NUM-1:0] gnt_mst,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               gnt_vld,
  output logic [MST_NUM-1:0] hold_mst
);

  // state     | meaning
  // ARB_IDLE  | no owner, grant all-zero
  // ARB_OWNED | master r_idx owns the bus, r_cnt counts its tenure

  localparam int unsigned        CNTW    = idx_w(QUANTUM);
  localparam logic [CNTW-1:0]    CNT_MAX = CNTW'(QUANTUM - 1);
  localparam logic [IDXW-1:0]    IDX_TOP = IDXW'(MST_NUM - 1);

  arb_state_e         r_state, w_nxt_state;
  logic [MST_NUM-1:0] r_gnt,   w_nxt_gnt;
  logic [IDXW-1:0]    r_idx,   w_nxt_idx;
  logic               r_vld,   w_nxt_vld;
  logic [CNTW-1:0]    r_cnt,   w_nxt_cnt;
  logic [IDXW-1:0]    r_ptr,   w_nxt_ptr;

  logic [MST_NUM-1:0] w_lock;
  logic [IDXW-1:0]    w_win;
  logic               w_found;
  logic               w_keep;

`ifdef RIB_ARB_LOCK_EN
  assign w_lock = lock_mst;
`else
  assign w_lock = lock_mst & '0;
`endif

  rib_rr_pick #(
    .MST_NUM (MST_NUM),
    .IDXW    (IDXW)
  ) u_pick (
    .req   (req_mst),
    .ptr   (r_ptr),
    .idx   (w_win),
    .found (w_found)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_idx   = r_idx;
    w_nxt_vld   = r_vld;
    w_nxt_cnt   = r_cnt;
    w_nxt_ptr   = r_ptr;
    w_keep      = 1'b0;

    if (r_state == ARB_OWNED) begin
      w_keep = req_mst[r_idx] && (w_lock[r_idx] || (r_cnt < CNT_MAX));
    end

    if (w_keep) begin
      w_nxt_cnt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNTW'(1);
    end else if (w_found) begin
      // The owner (if any) is re-picked only when nobody else is asking.
      w_nxt_state = ARB_OWNED;
      w_nxt_gnt   = {{(MST_NUM-1){1'b0}}, 1'b1} << w_win;
      w_nxt_idx   = w_win;
      w_nxt_vld   = 1'b1;
      w_nxt_cnt   = '0;
      w_nxt_ptr   = (w_win == IDX_TOP) ? '0 : w_win + IDXW'(1);
    end else begin
      w_nxt_state = ARB_IDLE;
      w_nxt_gnt   = '0;
      w_nxt_idx   = '0;
      w_nxt_vld   = 1'b0;
      w_nxt_cnt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_idx   <= w_nxt_idx;
      r_vld   <= w_nxt_vld;
      r_cnt   <= w_nxt_cnt;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign gnt_mst  = r_gnt;
  assign gnt_idx  = r_idx;
  assign gnt_vld  = r_vld;
  assign hold_mst = req_mst & ~r_gnt;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter (MST_NUM=3, QUANTUM=4) against a behavioural owner model.
module tb_rib_rr_arbiter;

  localparam int N = 3;
  localparam int Q = 4;
`ifdef RIB_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_b;
  logic [N-1:0] req_mst;
  logic [N-1:0] lock_mst;
  logic [N-1:0] gnt_mst;
  logic [1:0]   gnt_idx;
  logic         gnt_vld;
  logic [N-1:0] hold_mst;

  int n_chk = 0;
  int n_err = 0;

  // Model: current owner (-1 = idle), cycles owned so far, next rotation start.
  int m_owner = -1;
  int m_held  = 0;
  int m_next  = 0;

  rib_rr_arbiter #(
    .MST_NUM (N),
    .QUANTUM (Q)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req_mst  (req_mst),
    .lock_mst (lock_mst),
    .gnt_mst  (gnt_mst),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .hold_mst (hold_mst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_next  = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] rq, input logic [N-1:0] lk);
    bit keep;
    bit got;
    keep = 1'b0;
    got  = 1'b0;
    if (m_owner >= 0)
      keep = rq[m_owner] && ((LOCK_ON && lk[m_owner]) || (m_held < Q));
    if (keep) begin
      m_held++;
    end else begin
      for (int i = 0; i < N; i++) begin
        int m;
        m = (m_next + i) % N;
        if (!got && rq[m]) begin
          got     = 1'b1;
          m_owner = m;
          m_held  = 1;
          m_next  = (m + 1) % N;
        end
      end
      if (!got) begin
        m_owner = -1;
        m_held  = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_mst), 32'(m_gnt()));
    chk({tag, "_idx"}, 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, "_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] lk, input string tag);
    @(negedge clk);
    rst_b    = 1'b1;
    req_mst  = rq;
    lock_mst = lk;
    #1 chk({tag, "_hold"}, 32'(hold_mst), 32'(rq & ~m_gnt()));
    @(posedge clk);
    model_edge(rq, lk);
    #1 check_outputs(tag);
  endtask

  task automatic do_reset(input logic [N-1:0] rq);
    @(negedge clk);
    rst_b    = 1'b0;
    req_mst  = rq;
    lock_mst = '0;
    model_reset();
    #1;
    chk("rst_gnt", 32'(gnt_mst), 32'd0);
    chk("rst_vld", 32'(gnt_vld), 32'd0);
    chk("rst_hold", 32'(hold_mst), 32'(rq));
    @(posedge clk);
    #1 chk("rst_gnt_edge", 32'(gnt_mst), 32'd0);
  endtask

  initial begin
    rst_b    = 1'b0;
    req_mst  = '0;
    lock_mst = '0;

    // Reset with all masters requesting.
    do_reset(3'b111);

    // Rotation: m0, m1, m2 four cycles each, then m0 again, no gaps.
    for (int c = 0; c < 13; c++) begin
      step(3'b111, 3'b000, "rot");
      chk("rot_owner", 32'(gnt_mst), 32'(3'b001 << ((c / 4) % 3)));
    end

    // Single request from idle, then drop and idle.
    do_reset(3'b000);
    step(3'b100, 3'b000, "single");
    chk("single_gnt", 32'(gnt_mst), 32'b100);
    chk("single_idx", 32'(gnt_idx), 32'd2);
    chk("single_hold_after", 32'(hold_mst), 32'd0);
    step(3'b010, 3'b000, "to_m1");
    chk("to_m1_gnt", 32'(gnt_mst), 32'b010);
    step(3'b001, 3'b000, "drop");
    chk("drop_gnt", 32'(gnt_mst), 32'b001);
    step(3'b000, 3'b000, "idle");
    chk("idle_gnt", 32'(gnt_mst), 32'd0);
    chk("idle_vld", 32'(gnt_vld), 32'd0);

    // Lock held by m0 for ten cycles, then released.
    do_reset(3'b000);
    for (int c = 0; c < 11; c++) begin
      int exp_o;
      step(3'b111, (c < 10) ? 3'b001 : 3'b000, "lock");
      exp_o = LOCK_ON ? ((c < 10) ? 0 : 1) : ((c / 4) % 3);
      chk("lock_owner", 32'(gnt_mst), 32'(3'b001 << exp_o));
    end

    // Asynchronous reset between edges while m1 owns.
    do_reset(3'b000);
    step(3'b010, 3'b000, "pre_arst");
    chk("pre_arst_gnt", 32'(gnt_mst), 32'b010);
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    chk("arst_gnt", 32'(gnt_mst), 32'd0);
    chk("arst_vld", 32'(gnt_vld), 32'd0);
    chk("arst_idx", 32'(gnt_idx), 32'd0);
    step(3'b011, 3'b000, "post_arst");
    chk("post_arst_gnt", 32'(gnt_mst), 32'b001);

    // Randomized traffic with occasional locks against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] rq;
      logic [N-1:0] lk;
      rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rq = 3'b111;
      lk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step(rq, lk, "rand");
      if ($urandom_range(0, 149) == 0) do_reset(3'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
